// File: rtl/io_cond_pkg.sv
// Shared constants and sizing helpers for the pin conditioner bank.
package io_cond_pkg;

    localparam int unsigned LED_MODE_LEVEL  = 0;
    localparam int unsigned LED_MODE_ACT    = 1;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILT_CYCLES = 3;
    localparam int unsigned DEF_FILT_W      = 4;
    localparam int unsigned DEF_STRETCH_W   = 22;

    // Number of clock cycles in a stretch window of ms milliseconds.
    function automatic int unsigned stretch_cycles(input longint unsigned freq_hz,
                                                   input longint unsigned ms);
        longint unsigned cycles;
        cycles = (freq_hz / 64'd1000) * ms;
        return 32'(cycles);
    endfunction

    // Counter width whose all-ones value covers the requested stretch window.
    function automatic int unsigned stretch_width(input longint unsigned freq_hz,
                                                  input longint unsigned ms);
        return $clog2(stretch_cycles(freq_hz, ms) + 1);
    endfunction

endpackage

// File: rtl/io_cond_chan.sv
// One conditioner channel: inversion, synchroniser, glitch filter, edge pulses
// and LED driver.
module io_cond_chan
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned FILT_W      = DEF_FILT_W,
    parameter logic        INV         = 1'b0,
    parameter logic        RST_VAL     = 1'b0,
    parameter int unsigned LED_MODE    = LED_MODE_ACT,
    parameter int unsigned STRETCH_W   = DEF_STRETCH_W
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic filt_en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic led_c
);

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYCLES - 1);

    logic                   s_in;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [FILT_W-1:0]      cnt_q;
    logic [FILT_W-1:0]      cnt_d;
    logic                   lvl_d;

    assign s_in     = pin ^ INV;
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], s_in};
        end
    end

    // A new level is accepted only after FILT_CYCLES consecutive disagreeing samples.
    always_comb begin
        lvl_d = level;
        cnt_d = '0;
        if (!filt_en) begin
            lvl_d = sync_out;
        end else if (sync_out != level) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = sync_out;
            end else begin
                cnt_d = cnt_q + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= RST_VAL;
            cnt_q <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= lvl_d;
            cnt_q <= cnt_d;
            rise  <= lvl_d & ~level;
            fall  <= ~lvl_d & level;
        end
    end

    if (LED_MODE == LED_MODE_ACT) begin : g_act
        logic [STRETCH_W-1:0] scnt_q;

        // Reload on every accepted edge so bursts of activity keep the LED lit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                scnt_q <= '0;
            end else if (lvl_d != level) begin
                scnt_q <= '1;
            end else if (scnt_q != '0) begin
                scnt_q <= scnt_q - STRETCH_W'(1);
            end
        end

        assign led_c = (scnt_q != '0);
    end else begin : g_lvl
        assign led_c = level;
    end

endmodule

// File: rtl/io_cond_bank.sv
// Bank of NCH independent asynchronous-input conditioners between board pins
// and core/LED logic.
module io_cond_bank
    import io_cond_pkg::*;
#(
    parameter int unsigned    NCH         = 8,
    parameter int unsigned    SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned    FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned    FILT_W      = DEF_FILT_W,
    parameter logic [NCH-1:0] INV_MASK    = {NCH{1'b0}},
    parameter logic [NCH-1:0] RST_VAL     = {NCH{1'b0}},
    parameter int unsigned    LED_MODE    = LED_MODE_ACT,
    parameter int unsigned    STRETCH_W   = DEF_STRETCH_W
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] I_PIN,
    input  logic [NCH-1:0] I_FILT_EN,
    output logic [NCH-1:0] O_LEVEL,
    output logic [NCH-1:0] O_RISE,
    output logic [NCH-1:0] O_FALL,
    output logic [NCH-1:0] O_LED
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        io_cond_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .FILT_W      (FILT_W),
            .INV         (INV_MASK[i]),
            .RST_VAL     (RST_VAL[i]),
            .LED_MODE    (LED_MODE),
            .STRETCH_W   (STRETCH_W)
        ) u_chan (
            .clk     (CLK),
            .rst     (RST),
            .pin     (I_PIN[i]),
            .filt_en (I_FILT_EN[i]),
            .level   (O_LEVEL[i]),
            .rise    (O_RISE[i]),
            .fall    (O_FALL[i]),
            .led_c   (O_LED[i])
        );
    end

endmodule

// File: tb/tb_io_cond_bank.sv
// Scoreboard bench for io_cond_bank: expected pulses are queued by the stimulus
// and matched by an independent monitor.
module tb_io_cond_bank;

    logic       CLK;
    logic       RST;
    logic [3:0] I_PIN;
    logic [3:0] I_FILT_EN;
    logic [3:0] O_LEVEL;
    logic [3:0] O_RISE;
    logic [3:0] O_FALL;
    logic [3:0] O_LED;

    io_cond_bank #(
        .NCH         (4),
        .SYNC_STAGES (2),
        .FILT_CYCLES (3),
        .FILT_W      (4),
        .INV_MASK    (4'b0100),
        .RST_VAL     (4'b0100),
        .LED_MODE    (1),
        .STRETCH_W   (4)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .I_PIN     (I_PIN),
        .I_FILT_EN (I_FILT_EN),
        .O_LEVEL   (O_LEVEL),
        .O_RISE    (O_RISE),
        .O_FALL    (O_FALL),
        .O_LED     (O_LED)
    );

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   led_run[4];
    int   led_last[4];
    int   led_runs[4];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
        exp_t e;
        e.cyc   = c;
        e.rise  = r;
        e.fall  = f;
        e.level = l;
        sb.push_back(e);
    endtask

    // Pulse monitor: every pulse must match the head of the queue; overdue entries fail.
    always @(negedge CLK) begin
        exp_t e;
        if ((O_RISE | O_FALL) != 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got rise=%b fall=%b expected none (cyc %0d)",
                         O_RISE, O_FALL, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
                check("pulse_rise", 32'(O_RISE), 32'(e.rise));
                check("pulse_fall", 32'(O_FALL), 32'(e.fall));
                check("pulse_level", 32'(O_LEVEL), 32'(e.level));
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_pulse: got none expected rise=%b fall=%b at cyc %0d (now %0d)",
                     sb[0].rise, sb[0].fall, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    end

    // LED run-length recorder per channel.
    always @(negedge CLK) begin
        for (int c = 0; c < 4; c++) begin
            if (O_LED[c]) begin
                led_run[c] = led_run[c] + 1;
            end else if (led_run[c] != 0) begin
                led_last[c] = led_run[c];
                led_runs[c] = led_runs[c] + 1;
                led_run[c]  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            led_run[c]  = 0;
            led_last[c] = 0;
            led_runs[c] = 0;
        end
        RST       = 1'b1;
        I_PIN     = 4'b0000;
        I_FILT_EN = 4'b1111;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_level", 32'(O_LEVEL), 32'h4);
        check("rst_rise", 32'(O_RISE), 32'h0);
        check("rst_fall", 32'(O_FALL), 32'h0);
        check("rst_led", 32'(O_LED), 32'h0);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        check("post_rst_level", 32'(O_LEVEL), 32'h4);
        check("post_rst_led", 32'(O_LED), 32'h0);

        // Clean rise and fall on ch0
        I_PIN[0] = 1'b1;
        push(cyc + 5, 4'b0001, 4'b0000, 4'b0101);
        repeat (30) @(negedge CLK);
        check("step_led_len", 32'(led_last[0]), 32'd15);
        check("step_led_runs", 32'(led_runs[0]), 32'd1);
        check("step_level", 32'(O_LEVEL), 32'h5);
        I_PIN[0] = 1'b0;
        push(cyc + 5, 4'b0000, 4'b0001, 4'b0100);
        repeat (25) @(negedge CLK);
        check("fall_level", 32'(O_LEVEL), 32'h4);
        check("fall_led_runs", 32'(led_runs[0]), 32'd2);

        // Two-cycle glitch on ch1 with the filter enabled is rejected
        I_PIN[1] = 1'b1;
        repeat (2) @(negedge CLK);
        I_PIN[1] = 1'b0;
        repeat (20) @(negedge CLK);
        check("glitch_led_runs", 32'(led_runs[1]), 32'd0);
        check("glitch_level", 32'(O_LEVEL), 32'h4);

        // Same glitch in bypass passes through
        I_FILT_EN[1] = 1'b0;
        @(negedge CLK);
        I_PIN[1] = 1'b1;
        push(cyc + 3, 4'b0010, 4'b0000, 4'b0110);
        push(cyc + 5, 4'b0000, 4'b0010, 4'b0100);
        repeat (2) @(negedge CLK);
        I_PIN[1] = 1'b0;
        repeat (30) @(negedge CLK);
        check("bypass_led_len", 32'(led_last[1]), 32'd17);
        check("bypass_led_runs", 32'(led_runs[1]), 32'd1);
        I_FILT_EN[1] = 1'b1;

        // Retrigger on ch3: edges 5 cycles apart keep the LED lit
        I_PIN[3] = 1'b1;
        push(cyc + 5, 4'b1000, 4'b0000, 4'b1100);
        repeat (5) @(negedge CLK);
        I_PIN[3] = 1'b0;
        push(cyc + 5, 4'b0000, 4'b1000, 4'b0100);
        repeat (30) @(negedge CLK);
        check("retrig_led_len", 32'(led_last[3]), 32'd20);
        check("retrig_led_runs", 32'(led_runs[3]), 32'd1);

        // Reset while the ch0 filter is counting
        I_PIN[0] = 1'b1;
        repeat (4) @(negedge CLK);
        check("midrst_cnt2", 32'(u_dut.g_chan[0].u_chan.cnt_q), 32'd2);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_level", 32'(O_LEVEL), 32'h4);
        check("midrst_cnt0", 32'(u_dut.g_chan[0].u_chan.cnt_q), 32'd0);
        RST = 1'b0;
        push(cyc + 5, 4'b0001, 4'b0000, 4'b0101);
        repeat (20) @(negedge CLK);
        check("midrst_after_level", 32'(O_LEVEL), 32'h5);
        I_PIN[0] = 1'b0;
        push(cyc + 5, 4'b0000, 4'b0001, 4'b0100);
        repeat (25) @(negedge CLK);

        // Switch ch0 to bypass while the filter count is 1
        I_PIN[0] = 1'b1;
        repeat (3) @(negedge CLK);
        check("bsw_cnt1", 32'(u_dut.g_chan[0].u_chan.cnt_q), 32'd1);
        I_FILT_EN[0] = 1'b0;
        push(cyc + 1, 4'b0001, 4'b0000, 4'b0101);
        @(negedge CLK);
        check("bsw_cnt0", 32'(u_dut.g_chan[0].u_chan.cnt_q), 32'd0);
        check("bsw_level", 32'(O_LEVEL), 32'h5);
        I_FILT_EN[0] = 1'b1;
        repeat (20) @(negedge CLK);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_cond_bank.md
Name: io_cond_bank

Overview:
- Parametrised bank of asynchronous-input conditioners, the successor to the hand-written per-pin IOB flops and LED mirrors in the FPGA top.
- Each of NCH channels provides:
  - optional polarity inversion
  - N-stage synchroniser
  - per-channel glitch filter with runtime bypass
  - registered rise/fall pulses
  - LED driver in level or retriggerable activity-stretch mode
- Sits between board pins (SPI, UART RX, buttons) and core/LED logic in the FPGA top.

Parameters:
- NCH, 8, number of channels
- SYNC_STAGES, 2, synchroniser depth (>=2)
- FILT_CYCLES, 3, consecutive differing samples required to accept a new level (>=1)
- FILT_W, 4, filter counter width; requires FILT_CYCLES <= 2^FILT_W-1
- INV_MASK, {NCH{1'b0}}, per-channel pin inversion applied before the synchroniser
- RST_VAL, {NCH{1'b0}}, post-inversion reset level of sync/filter state (set 1 for idle-high lines)
- LED_MODE, 1, 0 = O_LED mirrors O_LEVEL, 1 = activity stretch
- STRETCH_W, 22, activity counter width (2^22-1 cycles is about 168 ms at 25 MHz)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- I_PIN  in  NCH  raw asynchronous pin inputs
- I_FILT_EN  in  NCH  per-channel filter enable (0 = bypass); synchronous to CLK
- O_LEVEL  out  NCH  conditioned level, registered
- O_RISE  out  NCH  one-cycle pulse, registered, asserted in the first cycle O_LEVEL is 1
- O_FALL  out  NCH  one-cycle pulse, registered, asserted in the first cycle O_LEVEL is 0
- O_LED  out  NCH  LED drive

Behaviour:
- Reset (async assert, sync deassert handled by the top-level reset source):
  - sync stages and O_LEVEL = RST_VAL
  - filter counters = 0, O_RISE = O_FALL = 0
  - stretch counters = 0, so O_LED = 0 in mode 1 and RST_VAL in mode 0
- Inversion:
  - s_in = I_PIN ^ INV_MASK, combinational.
  - This is the only logic before the first flop.
- Synchroniser: SYNC_STAGES flop chain; sync_out is the last stage.
- Filter, per channel, with lvl = O_LEVEL:
  - I_FILT_EN=0: lvl <= sync_out each cycle; cnt <= 0.
  - I_FILT_EN=1 and sync_out == lvl: cnt <= 0.
  - I_FILT_EN=1 and sync_out != lvl and cnt == FILT_CYCLES-1: lvl <= sync_out; cnt <= 0.
  - I_FILT_EN=1, otherwise: cnt <= cnt+1.
  - Any agreeing sample resets the count; a glitch shorter than FILT_CYCLES samples is fully rejected.
  - Toggling I_FILT_EN mid-count takes effect at the next edge; cnt is cleared when in bypass.
- Latency, pin edge to O_LEVEL change:
  - filter enabled: SYNC_STAGES+FILT_CYCLES clock edges
  - bypass: SYNC_STAGES+1 clock edges
- Edges:
  - O_RISE <= next_lvl & ~lvl; O_FALL <= ~next_lvl & lvl.
  - Both register at the same edge as lvl, so each pulse is exactly one cycle and coincides with the new level.
  - Rise and fall are never both set.
- Stretch (LED_MODE=1):
  - On a rise or fall, scnt <= 2^STRETCH_W-1, loaded at the same edge as the pulse.
  - Otherwise scnt decrements if nonzero and saturates at 0.
  - O_LED = (scnt != 0), decoded from the register, so O_LED rises in the same cycle as the pulse.
  - An edge while counting reloads the counter (retrigger).
  - LED high time for an isolated edge is exactly 2^STRETCH_W-1 cycles.
- Reset release with the pin differing from RST_VAL is treated as a genuine transition: it produces a normal, filtered edge after the usual latency.
- RST asserted mid-count aborts everything immediately; no pulse is emitted.
- Channels are fully independent; simultaneous edges on several channels are handled in parallel.

Decomposition:
- Package io_cond_pkg:
  - LED_MODE_LEVEL / LED_MODE_ACT constants
  - default SYNC_STAGES, FILT_CYCLES and STRETCH_W
  - helper function stretch_cycles(freq_hz, ms) for sizing STRETCH_W from CPU_CLOCK_FREQ
- Sub-module io_cond_chan implements one channel (sync, filter, edge, stretch).
- io_cond_bank instantiates NCH copies of io_cond_chan in a generate loop, slicing INV_MASK and RST_VAL per channel.

Test Plan (NCH=4, SYNC_STAGES=2, FILT_CYCLES=3, STRETCH_W=4, LED_MODE=1, INV_MASK=4'b0100, RST_VAL=4'b0100, I_FILT_EN=4'b1111 unless stated):
- Reset: hold RST with I_PIN=4'b0000 -> O_LEVEL=4'b0100, O_RISE=O_FALL=0, O_LED=0; after release O_LEVEL[2] stays 1 (inverted idle) and no pulses occur.
- Clean step: I_PIN[0] 0->1 sampled at edge 10 -> O_LEVEL[0]=1 and a single-cycle O_RISE[0] appear after edge 14; O_LED[0] stays high exactly 15 cycles.
- Glitch: I_PIN[1] high for 2 cycles with filter enabled -> no O_LEVEL, O_RISE or O_LED activity; repeat with I_FILT_EN[1]=0 -> one-cycle O_RISE then one-cycle O_FALL 2 cycles apart, and O_LED[1] high 17 cycles.
- Retrigger: two accepted edges on ch3 5 cycles apart -> O_LED[3] high continuously from the first pulse until 15 cycles after the second pulse.
- Reset mid-filter: I_PIN[0] rises, RST asserted when cnt=2 -> no pulse; release RST with pin still high -> O_RISE[0] after 5 edges.
- Bypass switch: clear I_FILT_EN[0] while cnt=1 -> level accepted at the next edge and the counter observed 0.
